ram_copy_engine: RTL and testbench

Block-copy initiator for the dual-port RAM. It takes a source address, a destination address and a word count. It streams words out of the RAM's asynchronous read port (addr2/dout2) and writes them back through the RAM's write port (wr/addr/din) at one word per cycle. It sits beside the CPU's memory map and offloads sprite and screen-buffer moves from software.

---
 rtl/copy_pkg.sv | 17 +
 rtl/copy_addr_counter.sv | 45 ++++
 rtl/ram_copy_engine.sv | 153 +++++++++++++++
 tb/tb_ram_copy_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/copy_pkg.sv
// Shared FSM state type and modulo-Nloc address adder for the RAM block-copy engine.
package copy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } copy_state_e;

    function automatic logic [31:0] add_mod(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/copy_addr_counter.sv
// Base register plus index counter: emits base+index mod Nloc and a terminal-count flag.
module copy_addr_counter
    import copy_pkg::*;
#(
    parameter int Nloc = 16,
    localparam int Abits = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Abits-1:0] base_i,
    input  logic             inc_i,
    input  logic [Abits:0]   last_i,
    output logic [Abits-1:0] addr_o,
    output logic             tc_o
);

    logic [Abits-1:0] base_q, base_d;
    logic [Abits:0]   idx_q, idx_d;

    always_comb begin
        base_d = base_q;
        idx_d  = idx_q;
        if (load_i) begin
            base_d = base_i;
            idx_d  = '0;
        end else if (inc_i) begin
            idx_d = idx_q + (Abits+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            idx_q  <= idx_d;
        end
    end

    assign addr_o = Abits'(add_mod(32'(base_q), 32'(idx_q), 32'(Nloc)));
    assign tc_o   = (idx_q == last_i);

endmodule

// File: rtl/ram_copy_engine.sv
// Block-copy initiator: streams words from the RAM async read port back through its write port.
// Optional COPY_FILL_EN adds fill/fill_value for constant fills that skip the reads.
module ram_copy_engine
    import copy_pkg::*;
#(
    parameter int Nloc  = 16,
    parameter int Dbits = 4,
    localparam int Abits = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [Abits-1:0] src,
    input  logic [Abits-1:0] dst,
    input  logic [Abits:0]   len,
    output logic             busy,
    output logic             done,
    output logic             wr,
    output logic [Abits-1:0] addr,
    output logic [Dbits-1:0] din,
    output logic [Abits-1:0] addr2,
`ifdef COPY_FILL_EN
    input  logic             fill,
    input  logic [Dbits-1:0] fill_value,
`endif
    input  logic [Dbits-1:0] dout2
);

    // state | meaning
    // IDLE  | waiting for start; latches src/dst/len
    // RUN   | one read per cycle, write of the previous word
    // DRAIN | final write on the port, no read
    // DONE  | one-cycle completion pulse

    copy_state_e      state_q, state_d;
    logic [Abits:0]   len_q, len_d;
    logic             wr_q, wr_d;
    logic [Abits-1:0] addr_q, addr_d;
    logic [Dbits-1:0] din_q, din_d;

    logic             accept, step;
    logic [Abits-1:0] rd_addr, wr_addr;
    logic             rd_tc, wr_tc;
    logic             fill_mode;
    logic [Dbits-1:0] fwd_word, new_word;

    copy_addr_counter #(.Nloc(Nloc)) u_rd_cnt (
        .clock  (clock),
        .reset  (reset),
        .load_i (accept),
        .base_i (src),
        .inc_i  (step),
        .last_i (len_q - (Abits+1)'(1)),
        .addr_o (rd_addr),
        .tc_o   (rd_tc)
    );

    copy_addr_counter #(.Nloc(Nloc)) u_wr_cnt (
        .clock  (clock),
        .reset  (reset),
        .load_i (accept),
        .base_i (dst),
        .inc_i  (step),
        .last_i (len_q),
        .addr_o (wr_addr),
        .tc_o   (wr_tc)
    );

    assign addr2 = (state_q == RUN && !fill_mode) ? rd_addr : '0;

    // The write in flight this cycle has not reached the RAM yet, so take it from din.
    assign fwd_word = (wr_q && (addr_q == addr2)) ? din_q : dout2;

`ifdef COPY_FILL_EN
    logic             fill_q;
    logic [Dbits-1:0] fill_value_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q       <= 1'b0;
            fill_value_q <= '0;
        end else if (accept) begin
            fill_q       <= fill;
            fill_value_q <= fill_value;
        end
    end

    assign fill_mode = fill_q;
    assign new_word  = fill_q ? fill_value_q : fwd_word;
`else
    assign fill_mode = 1'b0;
    assign new_word  = fwd_word;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        accept  = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                step   = 1'b1;
                wr_d   = 1'b1;
                addr_d = wr_addr;
                din_d  = new_word;
                if (rd_tc) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (wr_tc) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign len_d = accept ? len : len_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign wr   = wr_q;
    assign addr = addr_q;
    assign din  = din_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine with a behavioural 16x4 RAM and a write scoreboard.
module tb_ram_copy_engine;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [3:0] src, dst;
    logic [4:0] len;
    logic       busy, done, wr;
    logic [3:0] addr, din, addr2, dout2;
    logic       fill;
    logic [3:0] fill_value;

    logic [3:0] mem [16];
    logic       init_req;
    int         cyc_g = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int m [16];

    typedef struct {
        int a;
        int d;
        int c;
    } wexp_t;
    wexp_t sb [$];

    typedef struct {
        int src;
        int dst;
        int len;
        int exp_done;
    } vec_t;
    vec_t vt [7];

    ram_copy_engine #(.Nloc(16), .Dbits(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .wr         (wr),
        .addr       (addr),
        .din        (din),
        .addr2      (addr2),
`ifdef COPY_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .dout2      (dout2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc_g <= cyc_g + 1;
        if (init_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
        end else if (wr) begin
            mem[addr] <= din;
        end
    end

    assign dout2 = mem[addr2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_g);
        end
    endtask

    always @(negedge clock) begin
        if (wr === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write (cycle %0d)",
                         addr, din, cyc_g);
            end else begin
                wexp_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(addr), e.a);
                chk("wr_data", int'(din), e.d);
                chk("wr_cycle", cyc_g, e.c);
            end
        end
    end

    // Sequential forward-copy reference; writes land from cycle t0+2 onward.
    task automatic push_model(input int s, input int d, input int l, input int f,
                              input int fv, input int t0);
        for (int i = 0; i < l; i++) begin
            int a;
            int v;
            a = (d + i) % 16;
            v = (f != 0) ? fv : m[(s + i) % 16];
            m[a] = v;
            sb.push_back('{a, v, t0 + 2 + i});
        end
    endtask

    task automatic init_mem();
        init_req = 1'b1;
        for (int i = 0; i < 16; i++) m[i] = i;
        @(posedge clock); #1;
        init_req = 1'b0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), int'(mem[i]), m[i]);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic run_cmd(input int s, input int d, input int l, input int f,
                           input int fv, input int exp_done);
        push_model(s, d, l, f, fv, cyc_g);
        src = 4'(s); dst = 4'(d); len = 5'(l);
        fill = f[0]; fill_value = 4'(fv);
        start = 1'b1;
        for (int k = 1; k <= exp_done; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            chk("busy", int'(busy), int'(l != 0 && k <= l + 1));
            chk("done", int'(done), int'(k == exp_done));
            chk("addr2", int'(addr2), (k <= l && f == 0) ? (s + k - 1) % 16 : 0);
        end
        @(posedge clock); #1;
        chk("idle_busy", int'(busy), 0);
        check_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{2, 8, 4, 6};
        vt[1] = '{7, 3, 0, 1};
        vt[2] = '{14, 15, 3, 5};
        vt[3] = '{5, 5, 1, 3};
        vt[4] = '{1, 0, 20, 22};
        vt[5] = '{0, 1, 16, 18};
        vt[6] = '{3, 9, 31, 33};

        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_value = '0; init_req = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        init_req = 1'b0;
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr", int'(wr), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_din", int'(din), 0);
        chk("rst_addr2", int'(addr2), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        foreach (vt[i]) begin
            init_mem();
            run_cmd(vt[i].src, vt[i].dst, vt[i].len, 0, 0, vt[i].exp_done);
        end

        // Reset mid-run: only the writes presented before the reset edge land.
        init_mem();
        push_model(0, 8, 2, 0, 0, cyc_g);
        src = 4'd0; dst = 4'd8; len = 5'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_wr", int'(wr), 0);
        chk("mid_rst_addr", int'(addr), 0);
        chk("mid_rst_din", int'(din), 0);
        chk("mid_rst_addr2", int'(addr2), 0);
        repeat (4) @(posedge clock);
        #1;
        check_mem();

        // start held high: only the strobes in IDLE (cycles 0 and 7) are accepted.
        init_mem();
        push_model(2, 8, 4, 0, 0, cyc_g);
        push_model(2, 8, 4, 0, 0, cyc_g + 7);
        src = 4'd2; dst = 4'd8; len = 5'd4; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clock); #1;
            if (k == 8) start = 1'b0;
            @(negedge clock);
            chk("ign_busy", int'(busy), int'(k <= 5 || (k >= 8 && k <= 12)));
            chk("ign_done", int'(done), int'(k == 6 || k == 13));
        end
        @(posedge clock); #1;
        check_mem();

`ifdef COPY_FILL_EN
        init_mem();
        run_cmd(0, 3, 5, 1, 10, 7);
        init_mem();
        run_cmd(9, 14, 4, 0, 5, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
